set_cond_unit: RTL and testbench
================================

Name: set_cond_unit

Overview:
- Parametrised, pipelined compare-and-set unit for the ALU datapath; the next generation of the per-condition set modules (slt/seq/sne/sgt/slte/sge).
- Performs its own subtraction, so signed comparisons are overflow-correct and unsigned compares are supported.
- Selects one of ten set conditions per transaction.
- Valid/ready handshake on input and output; 2-stage pipeline with backpressure.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- RES_WIDTH, 32, result width; bit 0 carries the condition, upper bits are zero.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  unit accepts this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  4  condition select (encoding below).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_result  output  RES_WIDTH  {zeros, cond}.
- out_flags  output  4  {Z,N,C,V} from A-B.
- out_illegal  output  1  op was unassigned.

Behaviour:
- Reset is clocked only by rst, asynchronously. While rst is high:
  - s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_flags=0, out_illegal=0.
  - Data registers are also cleared.
  - In-flight transactions are dropped.
- Op encoding:
  - 0 SEQ, 1 SNE, 2 SLT, 3 SGT, 4 SLE, 5 SGE.
  - 6 SLTU, 7 SGTU, 8 SLEU, 9 SGEU.
  - 10-15 are illegal.
- Stage 1:
  - A transfer occurs when in_valid && in_ready.
  - On transfer, register a, b, op and set s1_valid.
- Stage 2:
  - Compute {C,D} = a + ~b + 1 at WIDTH+1 bits.
  - Z = (D==0); N = D[WIDTH-1]; V = (a[MSB]!=b[MSB]) && (D[MSB]!=a[MSB]).
  - Evaluate the condition, then register result, flags and illegal; set s2_valid.
- Condition definitions:
  - lt_s = N^V; lt_u = !C.
  - SEQ=Z; SNE=!Z.
  - SLT=lt_s; SGT=!lt_s && !Z; SLE=lt_s||Z; SGE=!lt_s.
  - Unsigned variants use lt_u in the same way.
  - Illegal op: cond=0, out_illegal=1, flags still computed.
- Latency: 2 cycles from input transfer to out_valid when not stalled. Throughput is 1 per cycle.
- Ready chain:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv.
  - The combinational path out_ready->in_ready is permitted.
- Output stability: while out_valid && !out_ready, out_result, out_flags and out_illegal hold stable.
- Full condition: both stages valid and out_ready=0 -> in_ready=0; at most 2 transactions are in flight.
- Simultaneous events: output drain and input accept happen in the same cycle when both are permitted, with no bubble.
- Ordering: results emerge strictly in order.
- Bubbles: an empty stage 1 with stage 2 draining clears s2_valid.
- Width rule: RES_WIDTH >= 1; bits RES_WIDTH-1:1 are always 0.

Decomposition:
- Package set_cond_pkg:
  - op encoding localparams (OP_SEQ..OP_SGEU);
  - flag bit index constants (F_Z=3, F_N=2, F_C=1, F_V=0).
- Sub-module cond_sub_flags (combinational, WIDTH-parametrised): a, b -> D, Z, N, C, V. Instantiated in stage 2; reusable by the adder/subtractor verification.

Test Plan:
1. SLT with a=0x7FFFFFFF, b=0x80000000 -> result 0, V=1. Then SLT with a=0x80000000, b=0x00000001 -> result 1, V=1, N=0 (overflow-correct).
2. SLTU with a=1, b=0xFFFFFFFF -> result 1, C=0. Then SGEU with the same operands -> result 0. Then SEQ with a=b=0x1234 -> result 1, flags Z=1, C=1.
3. Streaming: four back-to-back ops with out_ready=1 (SGT 5,3; SLE 3,3; SNE 0,0; SGE -1,0) -> results 1, 1, 0, 0 on cycles 2-5 after the first transfer; in_ready held at 1 throughout.
4. Backpressure: two transfers, then out_ready=0 for 3 cycles.
   - in_ready goes 0 once both stages are full.
   - The first result is held bit-stable.
   - On out_ready=1, results drain in order and in_ready returns to 1 in the same cycle.
5. Illegal op 12 with a=7, b=7 -> out_result=0, out_illegal=1, Z=1. The next legal op clears out_illegal.
6. Reset: rst asserted asynchronously mid-cycle with 2 transactions in flight -> out_valid falls before the next clk edge. After release, no stale result appears and the first new transfer completes with 2-cycle latency.

Source files
------------

// File: rtl/set_cond_pkg.sv
// Shared encodings for the compare-and-set unit: condition opcodes, flag bit
// positions and the condition evaluator used by stage 2.
package set_cond_pkg;

    localparam logic [3:0] OP_SEQ  = 4'd0;
    localparam logic [3:0] OP_SNE  = 4'd1;
    localparam logic [3:0] OP_SLT  = 4'd2;
    localparam logic [3:0] OP_SGT  = 4'd3;
    localparam logic [3:0] OP_SLE  = 4'd4;
    localparam logic [3:0] OP_SGE  = 4'd5;
    localparam logic [3:0] OP_SLTU = 4'd6;
    localparam logic [3:0] OP_SGTU = 4'd7;
    localparam logic [3:0] OP_SLEU = 4'd8;
    localparam logic [3:0] OP_SGEU = 4'd9;

    localparam int F_Z = 3;
    localparam int F_N = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    typedef struct packed {
        logic illegal;
        logic cond;
    } cond_res_t;

    // Unassigned opcodes report illegal with a zero condition.
    function automatic cond_res_t eval_cond(input logic [3:0] op, input logic [3:0] flags);
        cond_res_t r;
        logic      z;
        logic      lt_s;
        logic      lt_u;
        z         = flags[F_Z];
        lt_s      = flags[F_N] ^ flags[F_V];
        lt_u      = ~flags[F_C];
        r.illegal = 1'b0;
        r.cond    = 1'b0;
        case (op)
            OP_SEQ:  r.cond = z;
            OP_SNE:  r.cond = ~z;
            OP_SLT:  r.cond = lt_s;
            OP_SGT:  r.cond = ~lt_s & ~z;
            OP_SLE:  r.cond = lt_s | z;
            OP_SGE:  r.cond = ~lt_s;
            OP_SLTU: r.cond = lt_u;
            OP_SGTU: r.cond = ~lt_u & ~z;
            OP_SLEU: r.cond = lt_u | z;
            OP_SGEU: r.cond = ~lt_u;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/set_cond_unit_if.sv
// Valid/ready bus of the compare-and-set unit: operand/op request side and
// result/flags response side.
interface set_cond_unit_if #(
    parameter int WIDTH     = 32,
    parameter int RES_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [3:0]           in_op;
    logic                 out_valid;
    logic                 out_ready;
    logic [RES_WIDTH-1:0] out_result;
    logic [3:0]           out_flags;
    logic                 out_illegal;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_illegal
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_illegal
    );
endinterface

// File: rtl/set_cond_unit_flags.sv
// Combinational subtractor A-B producing the difference and {Z,N,C,V};
// C is the carry out of a + ~b + 1, i.e. set when no borrow occurred.
module cond_sub_flags #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] d_o,
    output logic             z_o,
    output logic             n_o,
    output logic             c_o,
    output logic             v_o
);
    logic [WIDTH:0] sum_s;

    assign sum_s = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign d_o   = sum_s[WIDTH-1:0];
    assign c_o   = sum_s[WIDTH];
    assign z_o   = (d_o == {WIDTH{1'b0}});
    assign n_o   = d_o[WIDTH-1];
    assign v_o   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (d_o[WIDTH-1] != a_i[WIDTH-1]);
endmodule

// File: rtl/set_cond_unit.sv
// Two-stage pipelined compare-and-set unit: stage 1 captures operands, stage 2
// subtracts, evaluates the selected condition and holds the result for the consumer.
module set_cond_unit
    import set_cond_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RES_WIDTH = 32
) (
    input logic            clk,
    input logic            rst,
    set_cond_unit_if.slave bus
);
    logic                 s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]     s1_a_q, s1_a_d;
    logic [WIDTH-1:0]     s1_b_q, s1_b_d;
    logic [3:0]           s1_op_q, s1_op_d;
    logic                 s2_valid_q, s2_valid_d;
    logic [RES_WIDTH-1:0] s2_result_q, s2_result_d;
    logic [3:0]           s2_flags_q, s2_flags_d;
    logic                 s2_illegal_q, s2_illegal_d;

    logic                 s1_adv_s;
    logic                 s2_adv_s;
    logic [WIDTH-1:0]     d_s;
    logic                 z_s, n_s, c_s, v_s;
    logic [3:0]           flags_s;
    cond_res_t            cres_s;
    logic                 unused_d_s;

    // A stage may advance when it is empty or its successor can take its content.
    assign s2_adv_s     = ~s2_valid_q | bus.out_ready;
    assign s1_adv_s     = ~s1_valid_q | s2_adv_s;
    assign bus.in_ready = s1_adv_s;

    cond_sub_flags #(.WIDTH(WIDTH)) u_sub (
        .a_i (s1_a_q),
        .b_i (s1_b_q),
        .d_o (d_s),
        .z_o (z_s),
        .n_o (n_s),
        .c_o (c_s),
        .v_o (v_s)
    );

    // The raw difference is only of interest to other users of the subtractor.
    assign unused_d_s = ^d_s;
    assign flags_s    = {z_s, n_s, c_s, v_s};
    assign cres_s     = eval_cond(s1_op_q, flags_s);

    // Stage 1 next state: capture operands on an input transfer.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_adv_s) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d  = bus.in_a;
                s1_b_d  = bus.in_b;
                s1_op_d = bus.in_op;
            end else begin
                s1_op_d = s1_op_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state: latch condition and flags; hold while the consumer stalls.
    always_comb begin
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_flags_d   = s2_flags_q;
        s2_illegal_d = s2_illegal_q;
        if (s2_adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d    = {RES_WIDTH{1'b0}};
                s2_result_d[0] = cres_s.cond;
                s2_flags_d     = flags_s;
                s2_illegal_d   = cres_s.illegal;
            end else begin
                s2_result_d = s2_result_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= {WIDTH{1'b0}};
            s1_b_q       <= {WIDTH{1'b0}};
            s1_op_q      <= 4'd0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= {RES_WIDTH{1'b0}};
            s2_flags_q   <= 4'd0;
            s2_illegal_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_flags_q   <= s2_flags_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign bus.out_valid   = s2_valid_q;
    assign bus.out_result  = s2_result_q;
    assign bus.out_flags   = s2_flags_q;
    assign bus.out_illegal = s2_illegal_q;
endmodule

// File: tb/tb_set_cond_unit.sv
// Self-checking bench for set_cond_unit: directed scenarios plus randomized
// traffic scored against an arithmetic reference model.
module tb_set_cond_unit;
    import set_cond_pkg::*;

    localparam int W  = 32;
    localparam int RW = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    set_cond_unit_if #(.WIDTH(W), .RES_WIDTH(RW)) bus ();
    set_cond_unit #(.WIDTH(W), .RES_WIDTH(RW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic       cond;
        logic [3:0] flags;
        logic       illegal;
    } exp_t;

    // Reference: plain signed/unsigned arithmetic comparisons.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        exp_t        e;
        longint      sa, sb, sd;
        logic [31:0] d;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sd = sa - sb;
        d  = a - b;
        e.flags   = {a == b, d[31], a >= b, (sd > SMAX) || (sd < SMIN)};
        e.illegal = 1'b0;
        e.cond    = 1'b0;
        case (op)
            OP_SEQ:  e.cond = (a == b);
            OP_SNE:  e.cond = (a != b);
            OP_SLT:  e.cond = (sa < sb);
            OP_SGT:  e.cond = (sa > sb);
            OP_SLE:  e.cond = (sa <= sb);
            OP_SGE:  e.cond = (sa >= sb);
            OP_SLTU: e.cond = (a < b);
            OP_SGTU: e.cond = (a > b);
            OP_SLEU: e.cond = (a <= b);
            OP_SGEU: e.cond = (a >= b);
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [RW-1:0] res_of(input logic c);
        logic [RW-1:0] r;
        r    = {RW{1'b0}};
        r[0] = c;
        return r;
    endfunction

    // Presents one op with out_ready=1; lat is edges from transfer to out_valid (-1 on timeout).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         output logic [RW-1:0] res, output logic [3:0] fl, output logic ill,
                         output int lat);
        logic acc;
        acc = 1'b0;
        lat = -1;
        res = {RW{1'b0}};
        fl  = 4'd0;
        ill = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_op     = op;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            #1;
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (acc) begin
            for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
                if (bus.out_valid) begin
                    lat = cyc;
                    res = bus.out_result;
                    fl  = bus.out_flags;
                    ill = bus.out_illegal;
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.out_valid, bus.out_result, bus.out_flags, bus.out_illegal} !== {1'b0, {RW{1'b0}}, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b r=%h f=%b i=%b required all zero",
                     bus.out_valid, bus.out_result, bus.out_flags, bus.out_illegal);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_slt_overflow();
        logic [RW-1:0] r; logic [3:0] f; logic il; int lat;
        issue(32'h7FFF_FFFF, 32'h8000_0000, OP_SLT, r, f, il, lat);
        n_checks++;
        if (lat !== 2 || r !== res_of(1'b0) || f[F_V] !== 1'b1) begin
            n_fail++;
            $display("FAIL slt_pos_neg: got lat=%0d r=%h f=%b required lat=2 r=0 V=1", lat, r, f);
        end
        issue(32'h8000_0000, 32'h0000_0001, OP_SLT, r, f, il, lat);
        n_checks++;
        if (lat !== 2 || r !== res_of(1'b1) || f[F_V] !== 1'b1 || f[F_N] !== 1'b0) begin
            n_fail++;
            $display("FAIL slt_neg_pos: got lat=%0d r=%h f=%b required lat=2 r=1 V=1 N=0", lat, r, f);
        end
    endtask

    task automatic test_unsigned();
        logic [RW-1:0] r; logic [3:0] f; logic il; int lat;
        issue(32'h1, 32'hFFFF_FFFF, OP_SLTU, r, f, il, lat);
        n_checks++;
        if (r !== res_of(1'b1) || f[F_C] !== 1'b0 || f !== model(32'h1, 32'hFFFF_FFFF, OP_SLTU).flags) begin
            n_fail++;
            $display("FAIL sltu: got r=%h f=%b required r=1 C=0", r, f);
        end
        issue(32'h1, 32'hFFFF_FFFF, OP_SGEU, r, f, il, lat);
        n_checks++;
        if (r !== res_of(1'b0)) begin
            n_fail++;
            $display("FAIL sgeu: got r=%h required 0", r);
        end
        issue(32'h1234, 32'h1234, OP_SEQ, r, f, il, lat);
        n_checks++;
        if (r !== res_of(1'b1) || f[F_Z] !== 1'b1 || f[F_C] !== 1'b1 || il !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_equal: got r=%h f=%b il=%b required r=1 Z=1 C=1 il=0", r, f, il);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] av [4];
        logic [31:0] bv [4];
        logic [3:0]  ov [4];
        logic        want [4];
        exp_t        e;
        int          got;
        av = '{32'd5, 32'd3, 32'd0, 32'hFFFF_FFFF};
        bv = '{32'd3, 32'd3, 32'd0, 32'd0};
        ov = '{OP_SGT, OP_SLE, OP_SNE, OP_SGE};
        want = '{1'b1, 1'b1, 1'b0, 1'b0};
        got = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = (k < 4) ? 1'b1 : 1'b0;
            if (k < 4) begin
                bus.in_a  = av[k];
                bus.in_b  = bv[k];
                bus.in_op = ov[k];
            end
            #1;
            if (k < 4) begin
                n_checks++;
                if (bus.in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_in_ready: cycle %0d got %b required 1", k, bus.in_ready);
                end
            end
            if (k >= 2 && k < 6) begin
                e = model(av[k-2], bv[k-2], ov[k-2]);
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_result !== res_of(want[k-2]) ||
                    bus.out_result !== res_of(e.cond) || bus.out_flags !== e.flags) begin
                    n_fail++;
                    $display("FAIL stream_result: cycle %0d got v=%b r=%h f=%b required v=1 r=%0d f=%b",
                             k, bus.out_valid, bus.out_result, bus.out_flags, want[k-2], e.flags);
                end
                got++;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (bus.out_valid !== 1'b0 || got !== 4) begin
            n_fail++;
            $display("FAIL stream_tail: got v=%b results=%0d required v=0 results=4", bus.out_valid, got);
        end
    endtask

    task automatic test_backpressure();
        exp_t ea, eb;
        ea = model(32'd1, 32'd2, OP_SLT);
        eb = model(32'd1, 32'd2, OP_SGEU);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a = 32'd1; bus.in_b = 32'd2; bus.in_op = OP_SLT;
        @(posedge clk);
        #1;
        bus.in_op = OP_SGEU;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_result !== res_of(ea.cond) ||
                bus.out_flags !== ea.flags || bus.out_illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: stall %0d got rdy=%b v=%b r=%h f=%b required rdy=0 v=1 r=%0d f=%b",
                         k, bus.in_ready, bus.out_valid, bus.out_result, bus.out_flags, ea.cond, ea.flags);
            end
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_result !== res_of(ea.cond)) begin
            n_fail++;
            $display("FAIL bp_release: got rdy=%b r=%h required rdy=1 r=%0d", bus.in_ready, bus.out_result, ea.cond);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== res_of(eb.cond) || bus.out_flags !== eb.flags) begin
            n_fail++;
            $display("FAIL bp_second: got v=%b r=%h f=%b required v=1 r=%0d f=%b",
                     bus.out_valid, bus.out_result, bus.out_flags, eb.cond, eb.flags);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: got v=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_illegal();
        logic [RW-1:0] r; logic [3:0] f; logic il; int lat;
        issue(32'd7, 32'd7, 4'd12, r, f, il, lat);
        n_checks++;
        if (r !== res_of(1'b0) || il !== 1'b1 || f[F_Z] !== 1'b1 || lat !== 2) begin
            n_fail++;
            $display("FAIL illegal_op: got r=%h il=%b f=%b lat=%0d required r=0 il=1 Z=1 lat=2", r, il, f, lat);
        end
        issue(32'd1, 32'd2, OP_SEQ, r, f, il, lat);
        n_checks++;
        if (il !== 1'b0 || r !== res_of(1'b0)) begin
            n_fail++;
            $display("FAIL illegal_clear: got il=%b r=%h required il=0 r=0", il, r);
        end
    endtask

    task automatic test_random();
        exp_t        q [$];
        exp_t        e;
        logic [31:0] a, b;
        logic [3:0]  op;
        logic        xin, xout;
        for (int cyc = 0; cyc < 400; cyc++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b = 32'h7FFF_FFFF;
            op = 4'($urandom_range(0, 15));
            bus.in_valid  = ((cyc < 360) && ($urandom_range(0, 3) != 0)) ? 1'b1 : 1'b0;
            bus.out_ready = ((cyc >= 360) || ($urandom_range(0, 2) != 0)) ? 1'b1 : 1'b0;
            bus.in_a  = a;
            bus.in_b  = b;
            bus.in_op = op;
            #1;
            n_checks++;
            if (bus.in_ready !== ((q.size() < 2) || bus.out_ready)) begin
                n_fail++;
                $display("FAIL rand_in_ready: cycle %0d got %b with %0d in flight out_ready=%b",
                         cyc, bus.in_ready, q.size(), bus.out_ready);
            end
            if (bus.out_valid === 1'b1) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious: cycle %0d got out_valid=1 required nothing in flight", cyc);
                end else begin
                    e = q[0];
                    if (bus.out_result !== res_of(e.cond) || bus.out_flags !== e.flags ||
                        bus.out_illegal !== e.illegal) begin
                        n_fail++;
                        $display("FAIL rand_result: cycle %0d got r=%h f=%b il=%b required r=%0d f=%b il=%b",
                                 cyc, bus.out_result, bus.out_flags, bus.out_illegal, e.cond, e.flags, e.illegal);
                    end
                end
            end
            xin  = bus.in_valid & bus.in_ready;
            xout = bus.out_valid & bus.out_ready;
            if (xout && q.size() > 0) void'(q.pop_front());
            if (xin) q.push_back(model(a, b, op));
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (q.size() != 0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_drain: got %0d left, out_valid=%b required 0 left, out_valid=0", q.size(), bus.out_valid);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [RW-1:0] r; logic [3:0] f; logic il; int lat;
        logic          stale;
        exp_t          e;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a = 32'd3; bus.in_b = 32'd4; bus.in_op = OP_SLT;
        @(posedge clk);
        #1;
        bus.in_op = OP_SNE;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_precond: got out_valid=%b required 1", bus.out_valid);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_result !== {RW{1'b0}} || bus.out_flags !== 4'd0) begin
            n_fail++;
            $display("FAIL arst_async: got v=%b r=%h f=%b required all zero before next edge",
                     bus.out_valid, bus.out_result, bus.out_flags);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (bus.out_valid !== 1'b0) stale = 1'b1;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (stale !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_stale: got out_valid=1 after reset required 0");
        end
        e = model(32'hFFFF_FFF0, 32'd16, OP_SGTU);
        issue(32'hFFFF_FFF0, 32'd16, OP_SGTU, r, f, il, lat);
        n_checks++;
        if (lat !== 2 || r !== res_of(e.cond) || f !== e.flags) begin
            n_fail++;
            $display("FAIL arst_first: got lat=%0d r=%h f=%b required lat=2 r=%0d f=%b", lat, r, f, e.cond, e.flags);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = 32'd0;
        bus.in_b      = 32'd0;
        bus.in_op     = 4'd0;
        bus.out_ready = 1'b0;
        test_reset();
        test_slt_overflow();
        test_unsigned();
        test_streaming();
        test_backpressure();
        test_illegal();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
